pipe_hazard_ctrl: RTL and testbench

//  Pipeline control for the 5-stage core. Drives the en and flush inputs of the PC, IF/ID and ID/EX registers.

---
 rtl/pipe_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage core: RAW stall, branch redirect,
// wrong-path squash and saturating stall/flush counters.
//
// Ports:
//   clk, reset           core clock, async active-high reset
//   ext_stall            external freeze of the whole front end
//   dec_*                decode-stage sources (valid, addrs, used flags)
//   ex_*                 ID/EX writer, branch type, zero flag, pc, offset
//   mem_WR_*, wb_WR_*    EX/MEM and MEM/WB writers
//   pc_en, pc_sel_branch PC enable and branch mux select
//   branch_target        ex_pc + ex_branch_offset (wraps)
//   if_id_en/flush       IF/ID enable and synchronous clear
//   id_ex_en/flush       ID/EX enable and synchronous clear
//   stall_count          RAW stall cycles (saturating)
//   flush_count          taken-branch redirects (saturating)
module pipe_hazard_ctrl #(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int INST_ADDR_WIDTH    = 9,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ext_stall,
  input  logic                          dec_valid,
  input  logic [REGFILE_ADDR_WIDTH-1:0] dec_R1_addr,
  input  logic [REGFILE_ADDR_WIDTH-1:0] dec_R2_addr,
  input  logic                          dec_R1_used,
  input  logic                          dec_R2_used,
  input  logic [REGFILE_ADDR_WIDTH-1:0] ex_WR_addr,
  input  logic                          ex_WR_en,
  input  logic                          ex_beq,
  input  logic                          ex_bneq,
  input  logic                          ex_zero,
  input  logic [INST_ADDR_WIDTH-1:0]    ex_pc,
  input  logic [INST_ADDR_WIDTH-1:0]    ex_branch_offset,
  input  logic [REGFILE_ADDR_WIDTH-1:0] mem_WR_addr,
  input  logic                          mem_WR_en,
  input  logic [REGFILE_ADDR_WIDTH-1:0] wb_WR_addr,
  input  logic                          wb_WR_en,
  output logic                          pc_en,
  output logic                          pc_sel_branch,
  output logic [INST_ADDR_WIDTH-1:0]    branch_target,
  output logic                          if_id_en,
  output logic                          if_id_flush,
  output logic                          id_ex_en,
  output logic                          id_ex_flush,
  output logic [CNT_WIDTH-1:0]          stall_count,
  output logic [CNT_WIDTH-1:0]          flush_count
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ONE = 1;

  state_t state_q, state_d;
  logic   taken, raw, hit1, hit2;
  logic   stall_inc, flush_inc;

  assign taken = (ex_beq & ex_zero) | (ex_bneq & ~ex_zero);

  // r0 is hardwired zero, so it never carries a dependency
  assign hit1 = (dec_R1_addr != '0) &
    ((ex_WR_en  & (ex_WR_addr  == dec_R1_addr)) |
     (mem_WR_en & (mem_WR_addr == dec_R1_addr)) |
     (wb_WR_en  & (wb_WR_addr  == dec_R1_addr)));

  assign hit2 = (dec_R2_addr != '0) &
    ((ex_WR_en  & (ex_WR_addr  == dec_R2_addr)) |
     (mem_WR_en & (mem_WR_addr == dec_R2_addr)) |
     (wb_WR_en  & (wb_WR_addr  == dec_R2_addr)));

  assign raw = dec_valid &
    ((dec_R1_used & hit1) | (dec_R2_used & hit2));

  assign branch_target = reset ? '0 :
    ex_pc + ex_branch_offset;

  always_comb begin
    state_d       = state_q;
    pc_en         = 1'b1;
    pc_sel_branch = 1'b0;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_flush   = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    if (reset) begin
      state_d     = RUN;
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (ext_stall) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      id_ex_en = 1'b0;
    end else begin
      unique case (state_q)
        // synchronous IMEM still returns the wrong-path word
        FLUSH: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = RUN;
        end
        RUN: begin
          if (taken) begin
            pc_sel_branch = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            flush_inc     = 1'b1;
            state_d       = FLUSH;
          end else if (raw) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state_q <= state_d;
      if (stall_inc && stall_count != '1)
        stall_count <= stall_count + ONE;
      if (flush_inc && flush_count != '1)
        flush_count <= flush_count + ONE;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed cases plus random stimulus,
// checked every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ext_stall, dec_valid;
  logic [4:0] dec_R1_addr, dec_R2_addr;
  logic       dec_R1_used, dec_R2_used;
  logic [4:0] ex_WR_addr, mem_WR_addr, wb_WR_addr;
  logic       ex_WR_en, mem_WR_en, wb_WR_en;
  logic       ex_beq, ex_bneq, ex_zero;
  logic [8:0] ex_pc, ex_branch_offset;

  logic        pc_en, pc_sel_branch, if_id_en, if_id_flush;
  logic        id_ex_en, id_ex_flush;
  logic [8:0]  branch_target;
  logic [15:0] stall_count, flush_count;

  logic        s_pc_en, s_pc_sel, s_if_en, s_if_fl;
  logic        s_idex_en, s_idex_fl;
  logic [8:0]  s_target;
  logic [1:0]  s_sc, s_fc;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_dut (
    .clk(clk), .reset(reset), .ext_stall(ext_stall),
    .dec_valid(dec_valid),
    .dec_R1_addr(dec_R1_addr), .dec_R2_addr(dec_R2_addr),
    .dec_R1_used(dec_R1_used), .dec_R2_used(dec_R2_used),
    .ex_WR_addr(ex_WR_addr), .ex_WR_en(ex_WR_en),
    .ex_beq(ex_beq), .ex_bneq(ex_bneq), .ex_zero(ex_zero),
    .ex_pc(ex_pc), .ex_branch_offset(ex_branch_offset),
    .mem_WR_addr(mem_WR_addr), .mem_WR_en(mem_WR_en),
    .wb_WR_addr(wb_WR_addr), .wb_WR_en(wb_WR_en),
    .pc_en(pc_en), .pc_sel_branch(pc_sel_branch),
    .branch_target(branch_target),
    .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  pipe_hazard_ctrl #(.CNT_WIDTH(2)) u_sat (
    .clk(clk), .reset(reset), .ext_stall(ext_stall),
    .dec_valid(dec_valid),
    .dec_R1_addr(dec_R1_addr), .dec_R2_addr(dec_R2_addr),
    .dec_R1_used(dec_R1_used), .dec_R2_used(dec_R2_used),
    .ex_WR_addr(ex_WR_addr), .ex_WR_en(ex_WR_en),
    .ex_beq(ex_beq), .ex_bneq(ex_bneq), .ex_zero(ex_zero),
    .ex_pc(ex_pc), .ex_branch_offset(ex_branch_offset),
    .mem_WR_addr(mem_WR_addr), .mem_WR_en(mem_WR_en),
    .wb_WR_addr(wb_WR_addr), .wb_WR_en(wb_WR_en),
    .pc_en(s_pc_en), .pc_sel_branch(s_pc_sel),
    .branch_target(s_target),
    .if_id_en(s_if_en), .if_id_flush(s_if_fl),
    .id_ex_en(s_idex_en), .id_ex_flush(s_idex_fl),
    .stall_count(s_sc), .flush_count(s_fc)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // shadow: one wrong-path fetch still to squash after a redirect
  bit m_sh = 0, n_sh = 0;
  int m_sc = 0, m_fc = 0, n_sc = 0, n_fc = 0;

  // expected control word {pc_en,pc_sel,if_en,if_fl,idex_en,idex_fl}
  logic [5:0] e_ctl;
  int         e_tgt;
  bit         e_raw, e_tk;
  logic [4:0] wa [3];
  bit         we [3];
  logic [4:0] ra [2];
  bit         ru [2];

  always @(negedge clk) begin
    wa = '{ex_WR_addr, mem_WR_addr, wb_WR_addr};
    we = '{ex_WR_en, mem_WR_en, wb_WR_en};
    ra = '{dec_R1_addr, dec_R2_addr};
    ru = '{dec_R1_used, dec_R2_used};
    e_raw = 0;
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 3; w++)
        if (dec_valid && ru[s] && ra[s] != 0 &&
            we[w] && wa[w] == ra[s])
          e_raw = 1;
    e_tk = (ex_beq && ex_zero) || (ex_bneq && !ex_zero);
    e_tgt = (int'(ex_pc) + int'(ex_branch_offset)) % 512;
    n_sh = m_sh; n_sc = m_sc; n_fc = m_fc;
    if (reset) begin
      e_ctl = 6'b000101; e_tgt = 0;
      n_sh = 0; n_sc = 0; n_fc = 0;
    end else if (ext_stall) begin
      e_ctl = 6'b000000;
    end else if (m_sh) begin
      e_ctl = 6'b101111; n_sh = 0;
    end else if (e_tk) begin
      e_ctl = 6'b111111; n_sh = 1; n_fc = m_fc + 1;
    end else if (e_raw) begin
      e_ctl = 6'b000011; n_sc = m_sc + 1;
    end else begin
      e_ctl = 6'b101010;
    end
    chk("ctl", {26'd0, pc_en, pc_sel_branch, if_id_en,
                if_id_flush, id_ex_en, id_ex_flush},
        {26'd0, e_ctl});
    chk("sat_ctl", {26'd0, s_pc_en, s_pc_sel, s_if_en,
                    s_if_fl, s_idex_en, s_idex_fl},
        {26'd0, e_ctl});
    chk("target", {23'd0, branch_target}, e_tgt);
    chk("stall_count", {16'd0, stall_count}, m_sc);
    chk("flush_count", {16'd0, flush_count}, m_fc);
    chk("sat_stall", {30'd0, s_sc}, (m_sc > 3) ? 3 : m_sc);
    chk("sat_flush", {30'd0, s_fc}, (m_fc > 3) ? 3 : m_fc);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sh <= 0; m_sc <= 0; m_fc <= 0;
    end else begin
      m_sh <= n_sh; m_sc <= n_sc; m_fc <= n_fc;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    ext_stall = 0; dec_valid = 0;
    dec_R1_addr = 0; dec_R2_addr = 0;
    dec_R1_used = 0; dec_R2_used = 0;
    ex_WR_addr = 0; ex_WR_en = 0;
    mem_WR_addr = 0; mem_WR_en = 0;
    wb_WR_addr = 0; wb_WR_en = 0;
    ex_beq = 0; ex_bneq = 0; ex_zero = 0;
    ex_pc = 0; ex_branch_offset = 0;
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd();
    int br;
    ext_stall = ($urandom_range(7) == 0);
    dec_valid = ($urandom_range(3) != 0);
    dec_R1_addr = 5'($urandom_range(3));
    dec_R2_addr = 5'($urandom_range(3));
    dec_R1_used = 1'($urandom);
    dec_R2_used = 1'($urandom);
    ex_WR_addr = 5'($urandom_range(3));
    mem_WR_addr = 5'($urandom_range(3));
    wb_WR_addr = 5'($urandom_range(3));
    ex_WR_en = 1'($urandom);
    mem_WR_en = 1'($urandom);
    wb_WR_en = 1'($urandom);
    br = $urandom_range(5);
    ex_beq = (br == 0);
    ex_bneq = (br == 1);
    ex_zero = 1'($urandom);
    ex_pc = 9'($urandom);
    ex_branch_offset = 9'($urandom);
  endtask

  initial begin
    // T1 reset with random inputs
    rnd();
    @(negedge clk);
    chk("rst_pc_en", {31'd0, pc_en}, 0);
    chk("rst_if_fl", {31'd0, if_id_flush}, 1);
    chk("rst_idex_fl", {31'd0, id_ex_flush}, 1);
    chk("rst_sc", {16'd0, stall_count}, 0);
    nx();
    reset = 0;
    idle();
    @(negedge clk);
    chk("run_en", {29'd0, pc_en, if_id_en, id_ex_en}, 7);

    // T2 RAW on r3 as writer walks EX->MEM->WB
    nx();
    dec_valid = 1; dec_R1_used = 1; dec_R1_addr = 3;
    ex_WR_en = 1; ex_WR_addr = 3;
    @(negedge clk);
    chk("raw_ex_pc_en", {31'd0, pc_en}, 0);
    chk("raw_ex_bubble", {31'd0, id_ex_flush}, 1);
    nx();
    ex_WR_en = 0; mem_WR_en = 1; mem_WR_addr = 3;
    @(negedge clk);
    chk("raw_mem_pc_en", {31'd0, pc_en}, 0);
    nx();
    mem_WR_en = 0; wb_WR_en = 1; wb_WR_addr = 3;
    @(negedge clk);
    chk("raw_wb_pc_en", {31'd0, pc_en}, 0);
    nx();
    wb_WR_en = 0;
    @(negedge clk);
    chk("raw_done_pc_en", {31'd0, pc_en}, 1);
    chk("raw_sc3", {16'd0, stall_count}, 3);

    // r0 never hazards
    nx();
    dec_R1_addr = 0; ex_WR_en = 1; ex_WR_addr = 0;
    @(negedge clk);
    chk("r0_pc_en", {31'd0, pc_en}, 1);
    nx();
    idle();
    @(negedge clk);
    chk("r0_sc", {16'd0, stall_count}, 3);

    // T3 branch with wrapping target
    nx();
    ex_beq = 1; ex_zero = 1;
    ex_pc = 9'h1F0; ex_branch_offset = 9'h020;
    @(negedge clk);
    chk("br_target", {23'd0, branch_target}, 32'h010);
    chk("br_sel", {31'd0, pc_sel_branch}, 1);
    chk("br_if_fl", {31'd0, if_id_flush}, 1);
    nx();
    idle();
    @(negedge clk);
    chk("sq_sel", {31'd0, pc_sel_branch}, 0);
    chk("sq_fl", {30'd0, if_id_flush, id_ex_flush}, 3);
    chk("sq_pc_en", {31'd0, pc_en}, 1);
    nx();
    @(negedge clk);
    chk("post_fl", {30'd0, if_id_flush, id_ex_flush}, 0);
    chk("br_fc1", {16'd0, flush_count}, 1);

    // T4 taken beats raw; raw ignored in the squash cycle
    nx();
    ex_bneq = 1; ex_zero = 0;
    ex_WR_en = 1; ex_WR_addr = 5;
    dec_valid = 1; dec_R2_used = 1; dec_R2_addr = 5;
    @(negedge clk);
    chk("pri_sel", {31'd0, pc_sel_branch}, 1);
    chk("pri_pc_en", {31'd0, pc_en}, 1);
    nx();
    ex_bneq = 0;
    @(negedge clk);
    chk("pri_sq_pc_en", {31'd0, pc_en}, 1);
    nx();
    idle();
    @(negedge clk);
    chk("pri_sc", {16'd0, stall_count}, 3);
    chk("pri_fc", {16'd0, flush_count}, 2);

    // T4 ext_stall freezes a pending taken branch
    nx();
    ext_stall = 1; ex_beq = 1; ex_zero = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("frz_en", {29'd0, pc_en, if_id_en, id_ex_en}, 0);
      chk("frz_sel", {31'd0, pc_sel_branch}, 0);
      nx();
    end
    ext_stall = 0;
    @(negedge clk);
    chk("frz_rel_sel", {31'd0, pc_sel_branch}, 1);
    chk("frz_fc", {16'd0, flush_count}, 2);
    nx();
    idle();
    @(negedge clk);
    chk("frz_fc3", {16'd0, flush_count}, 3);

    // T5 saturation of a 2-bit counter
    nx();
    reset = 1;
    nx();
    reset = 0;
    dec_valid = 1; dec_R1_used = 1; dec_R1_addr = 7;
    ex_WR_en = 1; ex_WR_addr = 7;
    repeat (5) @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    chk("sat_sc3", {30'd0, s_sc}, 3);
    chk("wide_sc5", {16'd0, stall_count}, 5);

    // T5 reset while squashing
    nx();
    ex_beq = 1; ex_zero = 1;
    nx();
    idle();
    #1;
    reset = 1;
    #1;
    chk("rstfl_pc_en", {31'd0, pc_en}, 0);
    chk("rstfl_if_fl", {31'd0, if_id_flush}, 1);
    chk("rstfl_fc", {16'd0, flush_count}, 0);
    chk("rstfl_sc", {30'd0, s_sc}, 0);
    nx();
    reset = 0;
    @(negedge clk);
    chk("rstfl_run",
        {27'd0, pc_en, if_id_en, id_ex_en,
         if_id_flush, id_ex_flush}, 5'b11100);

    // random phase, model checks every cycle
    for (int c = 0; c < 600; c++) begin
      nx();
      rnd();
      reset = ($urandom_range(63) == 0);
    end
    nx();
    reset = 0;
    idle();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
